ps2_host_tx: RTL and testbench

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_host_tx.sv | 194 +++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibits the bus and requests to send.
// It then shifts a byte plus odd parity out on device clock edges and checks the device ACK.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int START_CYCLES   = 100,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic [7:0] cmd_data,
  input  logic       cmd_send,
  inout  wire        PS2_CLK,
  inout  wire        PS2_DAT,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int MAX_AB  = (INHIBIT_CYCLES > START_CYCLES) ? INHIBIT_CYCLES : START_CYCLES;
  localparam int MAX_ABC = (MAX_AB > TIMEOUT_CYCLES) ? MAX_AB : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(MAX_ABC + 1);

  localparam logic [CNT_W-1:0] INH_LAST   = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    START,
    XFER,
    RECOVER
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       n_q, n_d, n_nxt;
  logic [7:0]       data_q, data_d;
  logic             par_q, par_d;
  logic             clk_oe_q, clk_oe_d;
  logic             dat_oe_q, dat_oe_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [2:0]       clk_s_q;
  logic [1:0]       dat_s_q;
  logic             clk_sync, dat_sync, clk_fall;

  // Open-drain drivers straight from flops: only ever pull low or float.
  assign PS2_CLK = clk_oe_q ? 1'b0 : 1'bz;
  assign PS2_DAT = dat_oe_q ? 1'b0 : 1'bz;

  assign busy  = (state_q != IDLE);
  assign done  = done_q;
  assign error = err_q;

  // clk_s_q[1] is the synchronized level, clk_s_q[2] its previous value.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      clk_s_q <= '1;
      dat_s_q <= '1;
    end else begin
      clk_s_q <= {clk_s_q[1:0], PS2_CLK};
      dat_s_q <= {dat_s_q[0], PS2_DAT};
    end
  end

  assign clk_sync = clk_s_q[1];
  assign clk_fall = clk_s_q[2] & ~clk_s_q[1];
  assign dat_sync = dat_s_q[1];
  assign n_nxt    = n_q + 4'd1;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      n_q      <= '0;
      data_q   <= '0;
      par_q    <= 1'b0;
      clk_oe_q <= 1'b0;
      dat_oe_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      n_q      <= n_d;
      data_q   <= data_d;
      par_q    <= par_d;
      clk_oe_q <= clk_oe_d;
      dat_oe_q <= dat_oe_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    n_d      = n_q;
    data_d   = data_q;
    par_d    = par_q;
    clk_oe_d = clk_oe_q;
    dat_oe_d = dat_oe_q;
    done_d   = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      IDLE: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        if (cmd_send) begin
          data_d   = cmd_data;
          par_d    = ~^cmd_data;
          cnt_d    = '0;
          n_d      = '0;
          clk_oe_d = 1'b1;
          state_d  = INHIBIT;
        end
      end

      INHIBIT: begin
        if (cnt_q == INH_LAST) begin
          cnt_d    = '0;
          dat_oe_d = 1'b1;
          state_d  = START;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      START: begin
        if (cnt_q == START_LAST) begin
          // Releasing CLK with DAT still low is the request-to-send / start bit.
          cnt_d    = '0;
          n_d      = '0;
          clk_oe_d = 1'b0;
          state_d  = XFER;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      XFER: begin
        if (clk_fall) begin
          cnt_d = '0;
          n_d   = n_nxt;
          if (n_nxt <= 4'd8) begin
            // Edge n carries data bit n-1, which is simply the old count.
            dat_oe_d = ~data_q[n_q[2:0]];
          end else if (n_nxt == 4'd9) begin
            dat_oe_d = ~par_q;
          end else if (n_nxt == 4'd10) begin
            dat_oe_d = 1'b0;
          end else begin
            dat_oe_d = 1'b0;
            done_d   = ~dat_sync;
            err_d    = dat_sync;
            state_d  = RECOVER;
          end
        end else if (cnt_q == TO_LAST) begin
          err_d    = 1'b1;
          clk_oe_d = 1'b0;
          dat_oe_d = 1'b0;
          cnt_d    = '0;
          state_d  = RECOVER;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      RECOVER: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        // The transfer already reported its outcome, so a stuck bus here only
        // bounds the wait and returns to IDLE without a second pulse.
        if ((clk_sync && dat_sync) || (cnt_q == TO_LAST)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d  = IDLE;
        cnt_d    = '0;
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: behavioural PS/2 device model on pulled-up open-drain lines,
// directed and random command bytes, timeout, missing-ACK and mid-transfer reset cases.
module tb_ps2_host_tx;

  localparam int INH  = 50;
  localparam int STC  = 4;
  localparam int TO   = 2000;
  localparam int HALF = 100;

  localparam int M_ACK     = 0;
  localparam int M_NOACK   = 1;
  localparam int M_TIMEOUT = 2;
  localparam int M_RESET   = 3;

  logic       CLOCK_50 = 1'b0;
  logic       resetn;
  logic [7:0] cmd_data;
  logic       cmd_send;
  wire        PS2_CLK;
  wire        PS2_DAT;
  logic       busy, done, error;
  logic       dev_clk_low, dev_dat_low;

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int both_cnt = 0;

  pullup (PS2_CLK);
  pullup (PS2_DAT);
  assign PS2_CLK = dev_clk_low ? 1'b0 : 1'bz;
  assign PS2_DAT = dev_dat_low ? 1'b0 : 1'bz;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .START_CYCLES  (STC),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .resetn  (resetn),
    .cmd_data(cmd_data),
    .cmd_send(cmd_send),
    .PS2_CLK (PS2_CLK),
    .PS2_DAT (PS2_DAT),
    .busy    (busy),
    .done    (done),
    .error   (error)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  always @(negedge CLOCK_50) begin
    if (done === 1'b1) done_cnt <= done_cnt + 1;
    if (error === 1'b1) err_cnt <= err_cnt + 1;
    if (done === 1'b1 && error === 1'b1) both_cnt <= both_cnt + 1;
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d (0x%0h) expected=%0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Line frame as the device sees it, bit 0 first: start, 8 data LSB first, odd parity, stop.
  function automatic logic [10:0] frame_of(input logic [7:0] d);
    int   ones;
    logic par;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    par = ((ones % 2) == 0) ? 1'b1 : 1'b0;
    return {1'b1, par, d, 1'b0};
  endfunction

  task automatic run_xfer(input logic [7:0] d, input int mode, input bit poke);
    logic [10:0] exp_f, got_f;
    int inh, stc, guard, c, dn0, er0, nfall;
    exp_f = frame_of(d);
    got_f = '0;
    dn0   = done_cnt;
    er0   = err_cnt;

    @(negedge CLOCK_50);
    cmd_data = d;
    cmd_send = 1'b1;
    @(negedge CLOCK_50);
    cmd_send = 1'b0;
    chk1($sformatf("busy_on_request_%02h", d), busy, 1'b1);

    inh = 0; stc = 0; guard = 0;
    while (PS2_CLK === 1'b0 && PS2_DAT === 1'b1 && guard < 20000) begin
      inh++; guard++; @(negedge CLOCK_50);
    end
    while (PS2_CLK === 1'b0 && PS2_DAT === 1'b0 && guard < 20000) begin
      stc++; guard++; @(negedge CLOCK_50);
    end
    chkn($sformatf("inhibit_len_%02h", d), inh, INH);
    chkn($sformatf("start_len_%02h", d), stc, STC);
    chk1($sformatf("clk_released_%02h", d), PS2_CLK, 1'b1);
    chk1($sformatf("start_bit_%02h", d), PS2_DAT, 1'b0);

    if (poke) begin
      cmd_data = 8'h12;
      cmd_send = 1'b1;
      @(negedge CLOCK_50);
      cmd_send = 1'b0;
    end

    if (mode == M_TIMEOUT) begin
      c = 0;
      while (error !== 1'b1 && c < 3 * TO) begin
        @(negedge CLOCK_50);
        c++;
      end
      chkn("timeout_latency", c, TO);
      @(negedge CLOCK_50);
      chk1("timeout_error_width", error, 1'b0);
      chk1("timeout_clk_released", PS2_CLK, 1'b1);
      chk1("timeout_dat_released", PS2_DAT, 1'b1);
      guard = 0;
      while (busy !== 1'b0 && guard < 50) begin
        @(negedge CLOCK_50);
        guard++;
      end
      chk1("timeout_busy_low", busy, 1'b0);
      chkn("timeout_done_count", done_cnt - dn0, 0);
      chkn("timeout_error_count", err_cnt - er0, 1);
    end else begin
      repeat (HALF / 2) @(negedge CLOCK_50);
      got_f[0] = PS2_DAT;
      nfall = (mode == M_RESET) ? 4 : 10;
      for (int b = 1; b <= nfall; b++) begin
        dev_clk_low = 1'b1;
        repeat (HALF) @(negedge CLOCK_50);
        dev_clk_low = 1'b0;
        @(negedge CLOCK_50);
        got_f[b] = PS2_DAT;
        repeat (HALF - 1) @(negedge CLOCK_50);
      end

      if (mode == M_RESET) begin
        chkn("pre_reset_frame", 32'(got_f[4:0]), 32'(exp_f[4:0]));
        chk1("pre_reset_busy", busy, 1'b1);
        chk1("pre_reset_dat_driven", PS2_DAT, 1'b0);
        #1 resetn = 1'b0;
        #1;
        chk1("reset_clk_z", PS2_CLK, 1'b1);
        chk1("reset_dat_z", PS2_DAT, 1'b1);
        chk1("reset_busy", busy, 1'b0);
        chk1("reset_done", done, 1'b0);
        chk1("reset_error", error, 1'b0);
        repeat (5) @(negedge CLOCK_50);
        resetn = 1'b1;
        repeat (5) @(negedge CLOCK_50);
        chkn("reset_abort_done_count", done_cnt - dn0, 0);
        chkn("reset_abort_error_count", err_cnt - er0, 0);
        chk1("reset_abort_busy", busy, 1'b0);
      end else begin
        chkn($sformatf("frame_%02h", d), 32'(got_f), 32'(exp_f));
        if (mode == M_ACK) dev_dat_low = 1'b1;
        dev_clk_low = 1'b1;
        repeat (HALF) @(negedge CLOCK_50);
        dev_clk_low = 1'b0;
        repeat (HALF) @(negedge CLOCK_50);
        dev_dat_low = 1'b0;
        guard = 0;
        while (busy !== 1'b0 && guard < 1000) begin
          @(negedge CLOCK_50);
          guard++;
        end
        chk1($sformatf("busy_end_%02h", d), busy, 1'b0);
        chkn($sformatf("done_count_%02h", d), done_cnt - dn0, (mode == M_ACK) ? 1 : 0);
        chkn($sformatf("error_count_%02h", d), err_cnt - er0, (mode == M_NOACK) ? 1 : 0);
        chk1($sformatf("idle_clk_%02h", d), PS2_CLK, 1'b1);
        chk1($sformatf("idle_dat_%02h", d), PS2_DAT, 1'b1);
      end
    end
  endtask

  initial begin
    logic [7:0] rb;
    resetn      = 1'b0;
    cmd_send    = 1'b0;
    cmd_data    = 8'h00;
    dev_clk_low = 1'b0;
    dev_dat_low = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_error", error, 1'b0);
    chk1("rst_clk_z", PS2_CLK, 1'b1);
    chk1("rst_dat_z", PS2_DAT, 1'b1);
    resetn = 1'b1;
    repeat (3) @(negedge CLOCK_50);

    run_xfer(8'hED, M_ACK, 1'b0);
    run_xfer(8'h00, M_ACK, 1'b0);
    run_xfer(8'hFF, M_ACK, 1'b0);
    run_xfer(8'h01, M_ACK, 1'b0);
    for (int k = 0; k < 4; k++) begin
      rb = 8'($urandom);
      run_xfer(rb, M_ACK, 1'b0);
    end

    rb = 8'($urandom);
    run_xfer(rb, M_TIMEOUT, 1'b0);

    rb = 8'($urandom);
    run_xfer(rb, M_NOACK, 1'b0);
    run_xfer(8'hF4, M_ACK, 1'b0);

    run_xfer(8'h00, M_RESET, 1'b0);
    run_xfer(8'hFF, M_ACK, 1'b1);
    repeat (300) @(negedge CLOCK_50);
    chk1("no_queued_busy", busy, 1'b0);
    chk1("no_queued_clk", PS2_CLK, 1'b1);

    chkn("done_error_overlap", both_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
